// File: rtl/sd_dat_pkg.sv
// sd_dat_pkg: transfer sequencer states and direction encoding shared with the DAT line engine
package sd_dat_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FIFO,
      ST_XFER,
      ST_BUSY_WAIT,
      ST_NEXT,
      ST_DONE,
      ST_ERROR
   } xfer_state_t;
   localparam logic DIR_WRITE = 1'b1;
   localparam logic DIR_READ = 1'b0;
endpackage

// File: rtl/sd_dat_xfer_ctrl_if.sv
// sd_dat_xfer_ctrl_if: register-file, FIFO and line-engine signals of the DAT transfer sequencer
interface sd_dat_xfer_ctrl_if #(
   parameter int BLK_CNT_W = 16,
   parameter int BLK_SIZE_W = 12,
   parameter int LVL_W = 10,
   parameter int TMO_W = 16
);
   logic start;
   logic abort;
   logic dir;
   logic [BLK_SIZE_W-1:0] blk_size;
   logic [BLK_CNT_W-1:0] blk_cnt;
   logic [TMO_W-1:0] timeout_val;
   logic [LVL_W-1:0] fifo_level;
   logic [LVL_W-1:0] fifo_space;
   logic phy_done;
   logic phy_crc_ok;
   logic card_busy;
   logic phy_start;
   logic phy_dir;
   logic [BLK_SIZE_W-3:0] phy_words;
   logic phy_abort;
   logic busy;
   logic xfer_done;
   logic err_crc;
   logic err_timeout;
   logic err_param;
   logic [BLK_CNT_W-1:0] blocks_done;
   modport master (
      output start, abort, dir, blk_size, blk_cnt, timeout_val, fifo_level, fifo_space,
             phy_done, phy_crc_ok, card_busy,
      input  phy_start, phy_dir, phy_words, phy_abort, busy, xfer_done,
             err_crc, err_timeout, err_param, blocks_done
   );
   modport slave (
      input  start, abort, dir, blk_size, blk_cnt, timeout_val, fifo_level, fifo_space,
             phy_done, phy_crc_ok, card_busy,
      output phy_start, phy_dir, phy_words, phy_abort, busy, xfer_done,
             err_crc, err_timeout, err_param, blocks_done
   );
endinterface

// File: rtl/sd_timeout_ctr.sv
// sd_timeout_ctr: saturating phase timer, expired when count reaches a nonzero limit
module sd_timeout_ctr #(
   parameter int W = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   input  logic [W-1:0] limit,
   output logic expired
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      if (reset || clear) cnt <= '0;
      else if (enable && cnt != '1) cnt <= cnt + 1'b1;
   assign expired = limit != '0 && cnt == limit;
endmodule

// File: rtl/sd_dat_xfer_ctrl.sv
// sd_dat_xfer_ctrl: block-transfer sequencer gating each DAT block on FIFO room, CRC status and card busy
module sd_dat_xfer_ctrl
   import sd_dat_pkg::*;
#(
   parameter int BLK_CNT_W = 16,
   parameter int BLK_SIZE_W = 12,
   parameter int LVL_W = 10,
   parameter int TMO_W = 16
) (
   input logic clk,
   input logic reset,
   sd_dat_xfer_ctrl_if.slave bus
);
   localparam int WW = BLK_SIZE_W - 2;
   localparam int CW = LVL_W > WW ? LVL_W : WW;
   xfer_state_t state;
   logic [BLK_CNT_W-1:0] remaining;
   logic [BLK_SIZE_W-1:0] req_words;
   logic fifo_ok, tmo_clr, tmo_exp;
   assign req_words = bus.blk_size >> 2;
   assign fifo_ok = bus.phy_dir == DIR_WRITE ? CW'(bus.fifo_level) >= CW'(bus.phy_words)
                                             : CW'(bus.fifo_space) >= CW'(bus.phy_words);
   // timer restarts on entry to XFER and again on entry to BUSY_WAIT (the phy_done cycle)
   assign tmo_clr = !(state == ST_XFER || state == ST_BUSY_WAIT) || (state == ST_XFER && bus.phy_done);
   sd_timeout_ctr #(.W(TMO_W)) u_tmo (
      .clk(clk),
      .reset(reset),
      .clear(tmo_clr),
      .enable(1'b1),
      .limit(bus.timeout_val),
      .expired(tmo_exp)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         remaining <= '0;
         bus.phy_start <= 1'b0;
         bus.phy_dir <= 1'b0;
         bus.phy_words <= '0;
         bus.phy_abort <= 1'b0;
         bus.busy <= 1'b0;
         bus.xfer_done <= 1'b0;
         bus.err_crc <= 1'b0;
         bus.err_timeout <= 1'b0;
         bus.err_param <= 1'b0;
         bus.blocks_done <= '0;
      end else begin
         bus.phy_start <= 1'b0;
         bus.phy_abort <= 1'b0;
         bus.xfer_done <= 1'b0;
         if (state != ST_IDLE && bus.abort) begin
            state <= ST_IDLE;
            bus.busy <= 1'b0;
            bus.phy_abort <= 1'b1;
            bus.xfer_done <= 1'b1;
         end else begin
            case (state)
               ST_IDLE:
                  if (bus.start && !bus.abort) begin
                     bus.phy_dir <= bus.dir;
                     bus.phy_words <= req_words[WW-1:0];
                     remaining <= bus.blk_cnt;
                     bus.err_crc <= 1'b0;
                     bus.err_timeout <= 1'b0;
                     bus.blocks_done <= '0;
                     bus.busy <= 1'b1;
                     bus.err_param <= req_words == '0 || bus.blk_cnt == '0;
                     state <= req_words == '0 || bus.blk_cnt == '0 ? ST_DONE : ST_WAIT_FIFO;
                  end
               ST_WAIT_FIFO:
                  if (fifo_ok) begin
                     state <= ST_XFER;
                     bus.phy_start <= 1'b1;
                  end
               ST_XFER:
                  if (bus.phy_done) begin
                     bus.err_crc <= !bus.phy_crc_ok;
                     state <= !bus.phy_crc_ok ? ST_ERROR : bus.phy_dir == DIR_WRITE ? ST_BUSY_WAIT : ST_NEXT;
                  end else if (tmo_exp) begin
                     bus.err_timeout <= 1'b1;
                     state <= ST_ERROR;
                  end
               ST_BUSY_WAIT:
                  if (!bus.card_busy) state <= ST_NEXT;
                  else if (tmo_exp) begin
                     bus.err_timeout <= 1'b1;
                     state <= ST_ERROR;
                  end
               ST_NEXT: begin
                  bus.blocks_done <= bus.blocks_done + 1'b1;
                  remaining <= remaining - 1'b1;
                  state <= remaining == BLK_CNT_W'(1) ? ST_DONE : ST_WAIT_FIFO;
               end
               ST_DONE: begin
                  state <= ST_IDLE;
                  bus.busy <= 1'b0;
                  bus.xfer_done <= 1'b1;
               end
               ST_ERROR: begin
                  state <= ST_IDLE;
                  bus.busy <= 1'b0;
                  bus.xfer_done <= 1'b1;
                  bus.phy_abort <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sd_dat_xfer_ctrl.sv
// tb_sd_dat_xfer_ctrl: directed table, corner sequences and randomized transfers against a block-level model
module tb_sd_dat_xfer_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   sd_dat_xfer_ctrl_if bus ();
   sd_dat_xfer_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   int checks = 0;
   int errors = 0;
   int d_arr[8];
   int b_arr[8];
   int t_start, t_err;
   typedef struct {
      logic dir;
      int bsz, cnt, tmo, crcf, d, b, st, dn;
      logic ec, et, ep;
   } vec_t;
   vec_t vt[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_sig(input string name, input bit want_done, input int bound);
      bit seen = 0;
      for (int k = 0; k < bound && !seen; k++) begin
         tick();
         seen = want_done ? bus.xfer_done : bus.phy_start;
      end
      chk(name, 32'(seen), 1);
   endtask

   // expected outcome from the block-level rules: each block either finishes or stops the transfer
   function automatic void model(input logic dir, input int words, cnt, tmo, crcf,
                                 output int st, output int dn, output logic c, output logic t, output logic p);
      st = 0; dn = 0; c = 0; t = 0;
      p = (words == 0 || cnt == 0);
      if (!p)
         for (int i = 0; i < cnt; i++) begin
            st++;
            if (tmo != 0 && d_arr[i] > tmo) begin t = 1; break; end
            if (i == crcf) begin c = 1; break; end
            if (dir && tmo != 0 && b_arr[i] > tmo) begin t = 1; break; end
            dn++;
         end
   endfunction

   task automatic run_xfer(input logic dir, input int bsz, cnt, tmo, crcf, exp_st, exp_dn,
                           input logic ec, et, ep);
      int words = (bsz >> 2) & 1023;
      int cyc = 0, blk = 0, done_cyc = -1000, bsy = 0, n_ab = 0, n_dn = 0;
      bit prev_ok = 0, fin = 0;
      t_start = -1; t_err = -1;
      bus.dir = dir; bus.blk_size = 12'(bsz); bus.blk_cnt = 16'(cnt); bus.timeout_val = 16'(tmo);
      bus.start = 1;
      for (int k = 0; k < 3000 && !fin; k++) begin
         tick();
         cyc++;
         bus.start = 0;
         if (cyc == 1) begin
            chk("busy_after_start", 32'(bus.busy), 1);
            chk("phy_words", 32'(bus.phy_words), words);
            chk("phy_dir", 32'(bus.phy_dir), 32'(dir));
         end
         if (bus.phy_start) begin
            chk("fifo_gate", 32'(prev_ok), 1);
            if (blk > 0) chk("block_gap_ge3", 32'(cyc - done_cyc >= 3), 1);
            if (t_start < 0) t_start = cyc;
            done_cyc = cyc + d_arr[blk];
            bsy = b_arr[blk];
            blk++;
         end
         if (bus.err_timeout && t_err < 0) t_err = cyc;
         n_ab += int'(bus.phy_abort);
         n_dn += int'(bus.xfer_done);
         if (bus.xfer_done) begin
            chk("busy_low_at_done", 32'(bus.busy), 0);
            fin = 1;
         end
         bus.phy_done = (cyc == done_cyc);
         bus.phy_crc_ok = (blk - 1 != crcf);
         bus.card_busy = dir && cyc > done_cyc && cyc <= done_cyc + bsy;
         bus.fifo_level = 10'($urandom_range(0, words + words / 2 + 1));
         bus.fifo_space = 10'($urandom_range(0, words + words / 2 + 1));
         prev_ok = dir ? 32'(bus.fifo_level) >= words : 32'(bus.fifo_space) >= words;
      end
      chk("xfer_done_seen", 32'(fin), 1);
      bus.phy_done = 0; bus.card_busy = 0;
      repeat (2) begin
         tick();
         n_ab += int'(bus.phy_abort);
         n_dn += int'(bus.xfer_done);
      end
      chk("phy_start_count", blk, exp_st);
      chk("blocks_done", 32'(bus.blocks_done), exp_dn);
      chk("err_crc", 32'(bus.err_crc), 32'(ec));
      chk("err_timeout", 32'(bus.err_timeout), 32'(et));
      chk("err_param", 32'(bus.err_param), 32'(ep));
      chk("phy_abort_count", n_ab, (ec || et) ? 1 : 0);
      chk("xfer_done_count", n_dn, 1);
   endtask

   initial begin
      int st, dn;
      logic c, t, p;
      bus.start = 0; bus.abort = 0; bus.dir = 0; bus.blk_size = 0; bus.blk_cnt = 0;
      bus.timeout_val = 0; bus.fifo_level = 0; bus.fifo_space = 0;
      bus.phy_done = 0; bus.phy_crc_ok = 0; bus.card_busy = 0;
      tick(); tick();
      chk("reset_flags", 32'({bus.busy, bus.phy_start, bus.phy_abort, bus.xfer_done,
                              bus.err_crc, bus.err_timeout, bus.err_param, bus.phy_dir}), 0);
      chk("reset_words", 32'(bus.phy_words), 0);
      chk("reset_blocks", 32'(bus.blocks_done), 0);
      reset = 0;
      tick();
      //                dir   bsz  cnt tmo crcf d   b   st dn ec et ep
      vt.push_back('{1'b1, 512, 3, 0, -1, 4, 5, 3, 3, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b0, 512, 2, 0, -1, 3, 0, 2, 2, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 512, 4, 0, 1, 2, 2, 2, 1, 1'b1, 1'b0, 1'b0});
      vt.push_back('{1'b0, 16, 1, 10, -1, 20, 0, 1, 0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b0, 16, 1, 10, -1, 10, 0, 1, 1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 2, 1, 0, -1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b0, 64, 0, 0, -1, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1});
      vt.push_back('{1'b1, 16, 1, 6, -1, 0, 9, 1, 0, 1'b0, 1'b1, 1'b0});
      vt.push_back('{1'b0, 7, 1, 0, -1, 0, 0, 1, 1, 1'b0, 1'b0, 1'b0});
      vt.push_back('{1'b1, 16, 2, 6, -1, 0, 5, 2, 2, 1'b0, 1'b0, 1'b0});
      foreach (vt[i]) begin
         for (int j = 0; j < 8; j++) begin d_arr[j] = vt[i].d; b_arr[j] = vt[i].b; end
         run_xfer(vt[i].dir, vt[i].bsz, vt[i].cnt, vt[i].tmo, vt[i].crcf,
                  vt[i].st, vt[i].dn, vt[i].ec, vt[i].et, vt[i].ep);
         if (vt[i].et && vt[i].d > vt[i].tmo) chk("timeout_latency", t_err - t_start, vt[i].tmo + 1);
      end

      // read gated on fifo_space until it covers a whole block
      bus.dir = 0; bus.blk_size = 512; bus.blk_cnt = 1; bus.timeout_val = 0; bus.fifo_space = 64;
      bus.start = 1; tick(); bus.start = 0;
      begin
         int n = 0;
         for (int k = 0; k < 20; k++) begin tick(); n += int'(bus.phy_start); end
         chk("no_start_low_space", n, 0);
      end
      bus.fifo_space = 128;
      wait_sig("start_after_space", 0, 3);
      bus.phy_done = 1; bus.phy_crc_ok = 1; tick(); bus.phy_done = 0;
      wait_sig("space_xfer_done", 1, 10);
      chk("space_blocks", 32'(bus.blocks_done), 1);

      // start and abort together in IDLE: abort wins
      bus.blk_size = 4; bus.blk_cnt = 1; bus.start = 1; bus.abort = 1; tick();
      bus.start = 0; bus.abort = 0;
      chk("start_abort_idle", 32'(bus.busy), 0);

      // timeout disabled: XFER waits; start while busy ignored; abort without error flags
      bus.fifo_space = 100; bus.start = 1; tick(); bus.start = 0;
      repeat (300) tick();
      chk("no_tmo_busy", 32'({bus.busy, bus.err_timeout}), 32'(2'b10));
      bus.blk_size = 64; bus.start = 1; tick(); bus.start = 0; tick();
      chk("start_while_busy", 32'(bus.phy_words), 1);
      bus.abort = 1; tick(); bus.abort = 0;
      chk("abort_pulses", 32'({bus.phy_abort, bus.xfer_done, bus.busy}), 32'(3'b110));
      chk("abort_no_err", 32'({bus.err_crc, bus.err_timeout, bus.err_param}), 0);

      // abort during BUSY_WAIT of block 2 keeps blocks_done
      bus.dir = 1; bus.blk_size = 16; bus.blk_cnt = 2; bus.fifo_level = 100;
      bus.start = 1; tick(); bus.start = 0;
      wait_sig("bw_start1", 0, 5);
      bus.phy_done = 1; bus.phy_crc_ok = 1; tick(); bus.phy_done = 0;
      wait_sig("bw_start2", 0, 8);
      chk("bw_blocks_mid", 32'(bus.blocks_done), 1);
      bus.phy_done = 1; tick(); bus.phy_done = 0; bus.card_busy = 1;
      repeat (3) tick();
      bus.abort = 1; tick(); bus.abort = 0; bus.card_busy = 0;
      chk("bw_abort", 32'({bus.phy_abort, bus.xfer_done, bus.busy}), 32'(3'b110));
      chk("bw_no_err", 32'({bus.err_crc, bus.err_timeout, bus.err_param}), 0);
      chk("bw_blocks_hold", 32'(bus.blocks_done), 1);
      tick();

      // reset during XFER
      bus.blk_cnt = 1; bus.start = 1; tick(); bus.start = 0;
      wait_sig("rst_start", 0, 5);
      tick();
      reset = 1; tick(); reset = 0;
      chk("rst_flags", 32'({bus.busy, bus.phy_start, bus.phy_abort, bus.xfer_done,
                            bus.err_crc, bus.err_timeout, bus.err_param, bus.phy_dir}), 0);
      chk("rst_words_blocks", 32'({bus.phy_words, bus.blocks_done}), 0);
      tick();
      for (int j = 0; j < 8; j++) begin d_arr[j] = 2; b_arr[j] = 1; end
      run_xfer(1'b0, 64, 2, 0, -1, 2, 2, 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 30; r++) begin
         int dir, cnt, words, bsz, tmo, crcf;
         dir = int'($urandom_range(0, 1));
         cnt = int'($urandom_range(0, 4));
         words = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 64));
         bsz = words * 4 + int'($urandom_range(0, 3));
         tmo = $urandom_range(0, 1) ? 0 : int'($urandom_range(3, 15));
         crcf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
         for (int j = 0; j < 8; j++) begin
            d_arr[j] = int'($urandom_range(0, 18));
            b_arr[j] = int'($urandom_range(0, 18));
            if (tmo != 0 && b_arr[j] == tmo) b_arr[j]++;
         end
         model(dir[0], words, cnt, tmo, crcf, st, dn, c, t, p);
         run_xfer(dir[0], bsz, cnt, tmo, crcf, st, dn, c, t, p);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sd_dat_xfer_ctrl.md
# sd_dat_xfer_ctrl

Block-transfer sequencer for the SD host DAT path. Takes a transfer request from the register file (direction, block size, block count, timeout), gates each block on FIFO occupancy, launches the DAT serializer/deserializer one block at a time, checks CRC status and card busy, and reports completion or error back to the register file. Sits between the register file, the data FIFO and the DAT line engine.

## Interface

- BLK_CNT_W, 16, width of block count and blocks_done
- BLK_SIZE_W, 12, width of block size in bytes (max 2048)
- LVL_W, 10, width of FIFO level/space inputs (32-bit words)
- TMO_W, 16, width of timeout value (clk cycles)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request pulse
- abort  in  1  one-cycle abort pulse
- dir  in  1  1 = write to card, 0 = read from card
- blk_size  in  BLK_SIZE_W  bytes per block; bits [1:0] ignored
- blk_cnt  in  BLK_CNT_W  blocks to transfer
- timeout_val  in  TMO_W  per-phase timeout; 0 disables
- fifo_level  in  LVL_W  words available to read out of FIFO
- fifo_space  in  LVL_W  free words in FIFO
- phy_done  in  1  pulse: line engine finished a block
- phy_crc_ok  in  1  CRC result, valid with phy_done
- card_busy  in  1  DAT0 held low by card
- phy_start  out  1  pulse: launch one block
- phy_dir  out  1  latched dir
- phy_words  out  BLK_SIZE_W-2  latched words per block
- phy_abort  out  1  pulse: stop line engine
- busy  out  1  transfer in progress
- xfer_done  out  1  pulse: transfer ended (ok or error)
- err_crc, err_timeout, err_param  out  1 each  sticky, cleared on next accepted start
- blocks_done  out  BLK_CNT_W  completed blocks of current transfer

## Operation

- States: IDLE, WAIT_FIFO, XFER, BUSY_WAIT, NEXT, DONE, ERROR.
- IDLE: on start, latch dir, words = blk_size>>2, remaining = blk_cnt; clear errors and blocks_done. If words==0 or blk_cnt==0: set err_param, go DONE. Else go WAIT_FIFO.
- WAIT_FIFO: write needs fifo_level >= words; read needs fifo_space >= words. No timeout. Met -> XFER.
- XFER: phy_start high on first cycle only. phy_done with phy_crc_ok=1 -> BUSY_WAIT (write) or NEXT (read). phy_done with phy_crc_ok=0 -> set err_crc, ERROR. Timeout -> set err_timeout, ERROR.
- BUSY_WAIT: card_busy low -> NEXT; timeout -> err_timeout, ERROR.
- NEXT: blocks_done+1, remaining-1; remaining becomes 0 -> DONE, else WAIT_FIFO.
- DONE: xfer_done pulse, -> IDLE. ERROR: phy_abort pulse, xfer_done pulse, -> IDLE.
- abort in any non-IDLE state: phy_abort pulse, xfer_done pulse, -> IDLE; no error flag set; blocks_done holds.
- start while busy: ignored. start and abort same cycle in IDLE: abort wins, start ignored.
- phy_done and timeout same cycle: phy_done wins.
- Timeout counter: cleared on entry to XFER and BUSY_WAIT, +1 per cycle; expiry when count == timeout_val and timeout_val != 0. Saturates, never wraps.

## Timing

- Reset values: state IDLE; all outputs 0 (busy, pulses, errors, blocks_done, phy_words, phy_dir).
- All outputs registered. start at edge N -> busy high from N+1; phy_start earliest at N+2 (WAIT_FIFO condition already true).
- busy high in every state except IDLE; low in the cycle after DONE/ERROR.
- Read path block-to-block gap minimum 3 cycles (phy_done -> NEXT -> WAIT_FIFO -> XFER start).
- Reset mid-transfer: next edge returns to reset values; no phy_abort or xfer_done pulse.

## Structure

- Package sd_dat_pkg: state enum, DIR_WRITE/DIR_READ constants, shared with the DAT line engine.
- Sub-module sd_timeout_ctr (clear, enable, limit, expired) instanced once.

## Test plan

- Write, blk_size=512, blk_cnt=3, fifo_level=128, phy_done+crc_ok each block, card_busy 5 cycles -> 3 phy_start pulses, phy_words=128, blocks_done=3, one xfer_done, no errors.
- Read, fifo_space=64 with words=128, raised to 128 after 20 cycles -> phy_start only after space >= 128.
- Write, phy_crc_ok=0 on block 2 of 4 -> err_crc=1, phy_abort pulse, blocks_done=1, busy low after.
- timeout_val=10, no phy_done -> err_timeout after 10 cycles in XFER; timeout_val=0 -> waits indefinitely.
- blk_size=2 -> err_param, xfer_done pulse, no phy_start; abort in BUSY_WAIT -> phy_abort, no error flags.
- reset asserted in XFER -> all outputs 0 next cycle; new start accepted normally.
